example_module: RTL and testbench



---
 rtl/example_pkg.sv | 13 +
 rtl/example_pipe_reg.sv | 27 ++
 rtl/example_module.sv | 69 ++++++
 tb/tb_example_module.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/example_pkg.sv
// example_pkg
// Shared constants and types for the example_module catalog element.
//   EX_WIDTH_DEFAULT : default operand/result width
//   EX_LATENCY_MAX   : largest supported pipeline depth
//   ex_word_t        : operand word at the default width
package example_pkg;

    localparam int EX_WIDTH_DEFAULT = 4;
    localparam int EX_LATENCY_MAX   = 4;

    typedef logic [EX_WIDTH_DEFAULT-1:0] ex_word_t;

endpackage : example_pkg

// File: rtl/example_pipe_reg.sv
// example_pipe_reg
// One WIDTH-bit pipeline register with asynchronous active-low clear.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low clear, q -> 0
//   d     : data in
//   q     : registered data out
module example_pipe_reg
    import example_pkg::*;
#(
    parameter int WIDTH = EX_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule : example_pipe_reg

// File: rtl/example_module.sv
// example_module
// Registered unsigned adder: C = A + B delayed by LATENCY register stages.
// A new operand pair is accepted every clock; there is no stall or handshake.
// Parameters:
//   WIDTH   : operand/result width (>= 1)
//   LATENCY : register stages from A/B to C (1..EX_LATENCY_MAX)
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears every stage and C
//   A, B  : unsigned operands
//   C     : registered sum
// Build option:
//   EXAMPLE_MODULE_SAT_EN : when defined the sum saturates at 2^WIDTH-1
//                           instead of wrapping; latency is unchanged.
module example_module
    import example_pkg::*;
#(
    parameter int WIDTH   = EX_WIDTH_DEFAULT,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C
);

    generate
        if (WIDTH < 1 || LATENCY < 1 || LATENCY > EX_LATENCY_MAX) begin : g_bad_param
            $error("example_module: WIDTH must be >= 1 and LATENCY must be 1..%0d",
                   EX_LATENCY_MAX);
        end
    endgenerate

    logic [WIDTH-1:0] sum_next;

`ifdef EXAMPLE_MODULE_SAT_EN
    logic [WIDTH:0] sum_full;

    // Clamp ahead of the first register so saturation costs no extra stage.
    assign sum_full = {1'b0, A} + {1'b0, B};
    assign sum_next = sum_full[WIDTH] ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];
`else
    // Carry-out is dropped: modulo 2^WIDTH.
    assign sum_next = A + B;
`endif

    // stage[0] is the combinational sum; stage[LATENCY] is the last register.
    logic [LATENCY:0][WIDTH-1:0] stage;

    assign stage[0] = sum_next;

    genvar k;
    generate
        for (k = 0; k < LATENCY; k++) begin : g_stage
            example_pipe_reg #(
                .WIDTH (WIDTH)
            ) u_reg (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (stage[k]),
                .q     (stage[k+1])
            );
        end
    endgenerate

    assign C = stage[LATENCY];

endmodule : example_module

// File: tb/tb_example_module.sv
// tb_example_module
// Directed bench for example_module at WIDTH=4. Two instances share the
// stimulus: u_dut1 (LATENCY=1) and u_dut3 (LATENCY=3). Expected values are
// hand-computed in the vector table, with one column per build flavour.
module tb_example_module;
    import example_pkg::*;

    logic     clk;
    logic     rst_n;
    ex_word_t A;
    ex_word_t B;
    ex_word_t C1;
    ex_word_t C3;

    int vectors;
    int miscompares;

    example_module #(.WIDTH(4), .LATENCY(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .C     (C1)
    );

    example_module #(.WIDTH(4), .LATENCY(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .C     (C3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        ex_word_t a;
        ex_word_t b;
        ex_word_t exp_wrap;
        ex_word_t exp_sat;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input ex_word_t act, input ex_word_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ex_word_t pick(input vec_t v);
`ifdef EXAMPLE_MODULE_SAT_EN
        return v.exp_sat;
`else
        return v.exp_wrap;
`endif
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Complement sweep: any A with B = ~A sums to all ones.
        for (int i = 0; i < 8; i++) begin
            ex_word_t ai;
            ai = ex_word_t'(i);
            tbl.push_back('{ai, ~ai, 4'd15, 4'd15});
        end
        tbl.push_back('{4'd3,  4'd4, 4'd7,  4'd7 });
        tbl.push_back('{4'd9,  4'd6, 4'd15, 4'd15});
        tbl.push_back('{4'd15, 4'd1, 4'd0,  4'd15});
        tbl.push_back('{4'd12, 4'd7, 4'd3,  4'd15});
        tbl.push_back('{4'd0,  4'd0, 4'd0,  4'd0 });
        tbl.push_back('{4'd8,  4'd8, 4'd0,  4'd15});
        tbl.push_back('{4'd7,  4'd8, 4'd15, 4'd15});
        tbl.push_back('{4'd1,  4'd2, 4'd3,  4'd3 });

        // Reset held: clocks must not load anything.
        rst_n = 1'b0;
        A     = 4'd5;
        B     = 4'd3;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold_lat1", C1, 4'd0);
        chk("reset_hold_lat3", C3, 4'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // Table: LATENCY=1 result appears on the sampling edge; LATENCY=3
        // shows the vector sampled two edges earlier.
        for (int i = 0; i < tbl.size(); i++) begin
            A = tbl[i].a;
            B = tbl[i].b;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_lat1", i), C1, pick(tbl[i]));
            if (i >= 2) chk($sformatf("vec%0d_lat3", i - 2), C3, pick(tbl[i-2]));
        end

        // Mid-cycle async reset: outputs clear without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_clr_lat1", C1, 4'd0);
        chk("async_clr_lat3", C3, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back pairs through LATENCY=3.
        A = 4'd1; B = 4'd1;
        @(posedge clk); #1;
        chk("lat3_e0", C3, 4'd0);
        chk("lat1_e0", C1, 4'd2);
        A = 4'd2; B = 4'd2;
        @(posedge clk); #1;
        chk("lat3_e1", C3, 4'd0);
        A = 4'd3; B = 4'd3;
        @(posedge clk); #1;
        chk("lat3_e2", C3, 4'd2);
        A = 4'd5; B = 4'd5;
        @(posedge clk); #1;
        chk("lat3_e3", C3, 4'd4);
        A = 4'd6; B = 4'd6;
        @(posedge clk); #1;
        chk("lat3_e4", C3, 4'd6);

        // Reset with 10 and 12 still in flight: they must never emerge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("flush_lat3", C3, 4'd0);
        @(negedge clk);
        A = 4'd1; B = 4'd2;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_e0", C3, 4'd0);
        A = 4'd0; B = 4'd0;
        @(posedge clk); #1;
        chk("post_rst_e1", C3, 4'd0);
        @(posedge clk); #1;
        chk("post_rst_e2", C3, 4'd3);
        @(posedge clk); #1;
        chk("post_rst_e3", C3, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_example_module
